pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program sequencer for the single-cycle core: holds the program counter, loads up to `NPROG` hardcoded program entry points on `Start`, and supports relative, absolute, call and return control flow. It replaces the fixed three-program counter ahead of instruction memory. Control-flow requests come from the decoder and branch-resolution logic in the same cycle they are issued.

## Interface
- `L`, default 10: PC width. Instruction memory depth is `2**L`.
- `OFFW`, default 8: width of `PCTarget` (unsigned offset or absolute low bits).
- `NPROG`, default 3: number of program entry points (1..8).
- `SDEPTH`, default 4: return-stack depth (power of 2, ≥2).
- `Clk` in 1: sole clock; all state changes on posedge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: level; rising edge selects the next program; PC holds while it is high.
- `Stall` in 1: hold PC and all state this cycle.
- `BranchUp` in 1: `PC <= PC - PCTarget`.
- `BranchDown` in 1: `PC <= PC + PCTarget`.
- `BranchAbs` in 1: `PC <= zero-extended PCTarget`.
- `Call` in 1: push `PC+1`; `PC <= PC + PCTarget`.
- `Ret` in 1: `PC <=` popped address.
- `PCTarget` in `OFFW`: offset or target.
- `ProgCtr` out `L`: current PC.
- `ProgIdx` out `$clog2(NPROG+1)`: index of the running program; `NPROG` means none.
- `Running` out 1: high in RUN.
- `Done` out 1: one-cycle pulse when a program ends.
- `StackErr` out 1: sticky; set on overflow or underflow.

## Operation
- States: IDLE, LOAD, RUN.
  - IDLE: PC holds at 0.
  - LOAD: `Start` is high and PC holds at the entry point.
  - RUN: PC advances.
- A `Start` rising edge (with `Start` registered low the previous cycle) in any state:
  - `ProgIdx <= nxt`, PC <= `PROG_START[nxt]`, state LOAD.
  - `nxt` is `ProgIdx+1`, or 0 from none. From `NPROG-1`, `nxt` wraps to none: PC <= 0, state IDLE.
- In LOAD, `Start` falling moves the state to RUN. The PC does not change on that cycle.
- In RUN, per-cycle priority, highest first: `Stall` > `Ret` > `Call` > `BranchAbs` > `BranchUp` > `BranchDown` > `PC+1`.
- In RUN, if the next PC would be 0: PC <= 0, state IDLE, `Done`=1 for one cycle, stack pointer cleared, `ProgIdx` kept.
- Arithmetic:
  - `PCTarget` is zero-extended to `L`.
  - Adds and subtracts are modulo `2**L`. Wrap-around is legal and silent.
  - Absolute targets beyond `OFFW` bits are not reachable.
- Return stack:
  - `Call` with the stack full: push dropped, branch still taken, `StackErr` set.
  - `Ret` with the stack empty: PC <= `PC+1`, `StackErr` set.
- Control inputs outside RUN are ignored, except `Start`.
- Reset values: `ProgCtr`=0, `ProgIdx`=`NPROG`, `Running`=0, `Done`=0, `StackErr`=0, stack pointer 0, state IDLE. `Reset` overrides `Start` in the same cycle.

## Timing
- All outputs are registered. A control input sampled at edge *n* is reflected on `ProgCtr` after edge *n*, with zero added latency.
- A `Start` rise sampled at edge *n* puts the entry address on `ProgCtr` after edge *n*. The first increment follows the edge after `Start` falls.
- `Reset` asserted mid-program takes effect at the next edge. The stack is discarded and no `Done` is issued.
- `Done` and the IDLE transition occur on the same edge the PC becomes 0.

## Configuration
- `PC_SEQ_STACK_EN` defined: return stack, `Call`, `Ret` and `StackErr` behave as above.
- `PC_SEQ_STACK_EN` undefined: no stack storage. `Call` behaves as `BranchDown`, `Ret` behaves as `PC+1`, and `StackErr` is tied to 0.

## Structure
- Shared package `pc_seq_pkg` holds:
  - the `PROG_START` entry-address array, sized by `NPROG`;
  - the state enum `{IDLE, LOAD, RUN}`;
  - `NONE_IDX`.
- Sub-module `pc_ret_stack`: a LIFO of `SDEPTH`×`L` with push, pop, full, empty and clear. It is instantiated only under `PC_SEQ_STACK_EN`.

## Test plan
- **Reset, then three Start pulses:**
  - Reset, then pulse `Start` three times (1 cycle high, 5 low, no branches).
  - Entry addresses from the default table `{1,2,4}`: `ProgCtr` loads 1, then 2, then 4, incrementing between pulses.
  - `ProgIdx` steps 0,1,2.
  - A fourth pulse returns the block to IDLE with PC 0 and `ProgIdx`=3.
- **Start held:** hold `Start` high 4 cycles. PC stays at 1 until the cycle after release, then goes 2,3.
- **Relative branches:**
  - At PC 10, `BranchUp` with `PCTarget`=3 gives 7.
  - `BranchDown` with 255 at PC 1000 (`L`=10) wraps to 231.
  - `BranchAbs` with 0x40 gives 64.
- **Priority:** `Stall`+`Call`+`BranchDown` in the same cycle holds the PC. `Call`+`BranchAbs` takes the call.
- **Stack (`PC_SEQ_STACK_EN`, `SDEPTH`=4):**
  - Five nested calls from PC 20 with offset 2: the 5th push is dropped and `StackErr` goes to 1.
  - Five returns follow. The 5th is an underflow and gives `PC+1`.
  - `StackErr` stays 1 until `Reset`.
- **End and reset mid-run:**
  - `BranchAbs` 0 in RUN gives `Done` pulse, `Running`=0 and PC held at 0 with `Start` low.
  - A separate run with `Reset` mid-call-chain gives all outputs at their reset values on the next edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared definitions for the program sequencer.
//   PROG_START : program entry addresses, one per program index
//                (covers the full 1..8 range of NPROG; a build uses the
//                first NPROG entries).
//   NONE_IDX   : "no program running" index for the default NPROG.
//   seq_state_e: sequencer FSM states.
package pc_seq_pkg;

  localparam int NPROG_MAX = 8;
  localparam int NPROG_DEF = 3;
  localparam int NONE_IDX  = NPROG_DEF;

  localparam int unsigned PROG_START [NPROG_MAX] = '{
    32'd1, 32'd2, 32'd4, 32'd8, 32'd16, 32'd32, 32'd64, 32'd128
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- control/status bundle of the program sequencer.
//   Controls (master -> slave): Start, Stall, BranchUp, BranchDown,
//     BranchAbs, Call, Ret, PCTarget[OFFW].
//   Status (slave -> master): ProgCtr[L], ProgIdx[IW], Running, Done,
//     StackErr.
//   IW must equal $clog2(NPROG+1) of the attached sequencer.
interface pc_sequencer_if #(
  parameter int L    = 10,
  parameter int OFFW = 8,
  parameter int IW   = 2
);

  logic            Start;
  logic            Stall;
  logic            BranchUp;
  logic            BranchDown;
  logic            BranchAbs;
  logic            Call;
  logic            Ret;
  logic [OFFW-1:0] PCTarget;

  logic [L-1:0]    ProgCtr;
  logic [IW-1:0]   ProgIdx;
  logic            Running;
  logic            Done;
  logic            StackErr;

  modport master (
    output Start, Stall, BranchUp, BranchDown, BranchAbs, Call, Ret, PCTarget,
    input  ProgCtr, ProgIdx, Running, Done, StackErr
  );

  modport slave (
    input  Start, Stall, BranchUp, BranchDown, BranchAbs, Call, Ret, PCTarget,
    output ProgCtr, ProgIdx, Running, Done, StackErr
  );

endinterface

// File: rtl/pc_ret_stack.sv
// pc_ret_stack -- SDEPTH x L return-address LIFO.
//   Clk, Reset   : clock, synchronous active-high reset (empties the stack)
//   clear_i      : empty the stack (wins over push/pop)
//   push_i       : push push_data_i (ignored when full)
//   pop_i        : pop top entry (ignored when empty or pushing)
//   pop_data_o   : current top entry, valid combinationally when !empty_o
//   full_o       : SDEPTH entries held
//   empty_o      : no entries held
module pc_ret_stack #(
  parameter int L      = 10,
  parameter int SDEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [L-1:0] push_data_i,
  output logic [L-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int SPW = $clog2(SDEPTH);
  localparam logic [SPW:0] SP_FULL = (SPW + 1)'(SDEPTH);
  localparam logic [SPW:0] SP_ONE  = (SPW + 1)'(1);

  logic [SPW:0] sp_q, sp_d;
  logic [SPW:0] sp_m1;
  logic [L-1:0] mem_q [SDEPTH];
  logic         do_push, do_pop;

  assign full_o  = (sp_q == SP_FULL);
  assign empty_o = (sp_q == '0);
  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i & ~push_i;
  assign sp_m1   = sp_q - SP_ONE;

  // The sequencer needs the return address in the same cycle Ret is
  // issued, so the top entry is read asynchronously from registers.
  assign pop_data_o = mem_q[sp_m1[SPW-1:0]];

  always_comb begin
    sp_d = sp_q;
    if (clear_i) begin
      sp_d = '0;
    end else if (do_push) begin
      sp_d = sp_q + SP_ONE;
    end else if (do_pop) begin
      sp_d = sp_m1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem_q[sp_q[SPW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter / sequencer for the single-cycle core.
//   Clk    : sole clock, all state on posedge
//   Reset  : synchronous, active-high; overrides Start
//   bus    : pc_sequencer_if.slave
//            in : Start, Stall, BranchUp, BranchDown, BranchAbs, Call, Ret,
//                 PCTarget
//            out: ProgCtr, ProgIdx, Running, Done, StackErr (all registered)
// Build option: define PC_SEQ_STACK_EN for the return stack (Call pushes,
// Ret pops, StackErr flags over/underflow). Without it, Call acts as
// BranchDown, Ret as PC+1 and StackErr is 0.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int L      = 10,
  parameter int OFFW   = 8,
  parameter int NPROG  = NPROG_DEF,
  parameter int SDEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  pc_sequencer_if.slave bus
);

  localparam int IW = $clog2(NPROG + 1);
  localparam logic [IW-1:0] NONE_I = IW'(NPROG);
  localparam logic [IW-1:0] LAST_I = IW'(NPROG - 1);
  localparam logic [IW-1:0] ONE_I  = IW'(1);
  localparam logic [L-1:0]  ONE_L  = L'(1);

  // Reject illegal configurations at elaboration.
  if (NPROG < 1 || NPROG > NPROG_MAX) begin : g_bad_nprog
    $error("pc_sequencer: NPROG must be 1..8");
  end
  if (SDEPTH < 2 || (SDEPTH & (SDEPTH - 1)) != 0) begin : g_bad_sdepth
    $error("pc_sequencer: SDEPTH must be a power of 2 and >= 2");
  end

  seq_state_e    state_q, state_d;
  logic [L-1:0]  pc_q, pc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          start_q;
  logic          running_q, running_d;
  logic          done_q, done_d;

  logic          start_rise;
  logic [IW-1:0] nxt;
  logic [L-1:0]  tgt_ext;
  logic [L-1:0]  pc_plus1;
  logic [L-1:0]  pc_run;
  logic          stk_clr;

`ifdef PC_SEQ_STACK_EN
  logic          err_q, err_d;
  logic          stk_push, stk_pop;
  logic [L-1:0]  stk_top;
  logic          stk_full, stk_empty;

  pc_ret_stack #(
    .L      (L),
    .SDEPTH (SDEPTH)
  ) u_ret_stack (
    .Clk         (Clk),
    .Reset       (Reset),
    .clear_i     (stk_clr),
    .push_i      (stk_push),
    .pop_i       (stk_pop),
    .push_data_i (pc_plus1),
    .pop_data_o  (stk_top),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );
`endif

  assign start_rise = bus.Start & ~start_q;
  assign tgt_ext    = L'(bus.PCTarget);
  assign pc_plus1   = pc_q + ONE_L;

  // Program index that the next Start rise selects; NONE_I after the last.
  always_comb begin
    if (idx_q == NONE_I) begin
      nxt = '0;
    end else if (idx_q == LAST_I) begin
      nxt = NONE_I;
    end else begin
      nxt = idx_q + ONE_I;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    pc_run  = pc_plus1;
    stk_clr = 1'b0;
`ifdef PC_SEQ_STACK_EN
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif

    if (start_rise) begin
      // A new program discards any return addresses left by the old one.
      stk_clr = 1'b1;
      idx_d   = nxt;
      if (nxt == NONE_I) begin
        pc_d    = '0;
        state_d = IDLE;
      end else begin
        pc_d    = L'(PROG_START[nxt]);
        state_d = LOAD;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (!bus.Start) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!bus.Stall) begin
            if (bus.Ret) begin
`ifdef PC_SEQ_STACK_EN
              if (stk_empty) begin
                err_d = 1'b1;
              end else begin
                stk_pop = 1'b1;
                pc_run  = stk_top;
              end
`else
              pc_run = pc_plus1;
`endif
            end else if (bus.Call) begin
              pc_run = pc_q + tgt_ext;
`ifdef PC_SEQ_STACK_EN
              if (stk_full) begin
                err_d = 1'b1;
              end else begin
                stk_push = 1'b1;
              end
`endif
            end else if (bus.BranchAbs) begin
              pc_run = tgt_ext;
            end else if (bus.BranchUp) begin
              pc_run = pc_q - tgt_ext;
            end else if (bus.BranchDown) begin
              pc_run = pc_q + tgt_ext;
            end

            // Reaching address 0 ends the program; the stack clear wins
            // over any push/pop issued in the same cycle.
            if (pc_run == '0) begin
              pc_d    = '0;
              state_d = IDLE;
              done_d  = 1'b1;
              stk_clr = 1'b1;
            end else begin
              pc_d = pc_run;
            end
          end
        end
        default: begin
          pc_d = pc_q;
        end
      endcase
    end
  end

  assign running_d = (state_d == RUN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      idx_q     <= NONE_I;
      start_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      idx_q     <= idx_d;
      start_q   <= bus.Start;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

`ifdef PC_SEQ_STACK_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign bus.StackErr = err_q;
`else
  assign bus.StackErr = 1'b0;
`endif

  assign bus.ProgCtr = pc_q;
  assign bus.ProgIdx = idx_q;
  assign bus.Running = running_q;
  assign bus.Done    = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- scoreboard bench for pc_sequencer (default parameters).
// Expected outputs are queued when each stimulus cycle is driven and popped
// and compared one edge later. Works with or without PC_SEQ_STACK_EN.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int L      = 10;
  localparam int OFFW   = 8;
  localparam int NPROG  = 3;
  localparam int SDEPTH = 4;
  localparam int IW     = $clog2(NPROG + 1);

`ifdef PC_SEQ_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  // Control vector order: {Start, Stall, Ret, Call, BranchAbs, BranchUp, BranchDown}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_START = 7'b1000000;
  localparam logic [6:0] C_STALL = 7'b0100000;
  localparam logic [6:0] C_RET   = 7'b0010000;
  localparam logic [6:0] C_CALL  = 7'b0001000;
  localparam logic [6:0] C_ABS   = 7'b0000100;
  localparam logic [6:0] C_UP    = 7'b0000010;
  localparam logic [6:0] C_DN    = 7'b0000001;

  typedef struct {
    string tag;
    int    pc;
    int    idx;
    bit    run;
    bit    done;
    bit    err;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  always #5 Clk = ~Clk;

  pc_sequencer_if #(.L(L), .OFFW(OFFW), .IW(IW)) sif ();

  pc_sequencer #(
    .L      (L),
    .OFFW   (OFFW),
    .NPROG  (NPROG),
    .SDEPTH (SDEPTH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (sif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, then compare
  // the DUT outputs 1 time unit after the edge.
  task automatic step(input string tag, input bit rst, input logic [6:0] c, input int tgt,
                      input int pc, input int idx, input bit run, input bit done, input bit err);
    exp_t e;
    Reset = rst;
    {sif.Start, sif.Stall, sif.Ret, sif.Call, sif.BranchAbs, sif.BranchUp, sif.BranchDown} = c;
    sif.PCTarget = OFFW'(tgt);
    e.tag = tag; e.pc = pc; e.idx = idx; e.run = run; e.done = done; e.err = err;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    $display("[%0t] %-10s pc=%0d idx=%0d run=%0b done=%0b err=%0b", $time, e.tag,
             sif.ProgCtr, sif.ProgIdx, sif.Running, sif.Done, sif.StackErr);
    check({e.tag, ".pc"},   32'(sif.ProgCtr), 32'(e.pc));
    check({e.tag, ".idx"},  32'(sif.ProgIdx), 32'(e.idx));
    check({e.tag, ".run"},  32'(sif.Running), 32'(e.run));
    check({e.tag, ".done"}, 32'(sif.Done),    32'(e.done));
    check({e.tag, ".err"},  32'(sif.StackErr), 32'(e.err));
  endtask

  initial begin
    int entry [3];
    int ret_stk [5];
    int e;
    entry   = '{1, 2, 4};
    ret_stk = '{27, 25, 23, 21, 22};
    e = 0;

    // Reset, including Reset overriding Start.
    step("rst_start", 1'b1, C_START, 0, 0, NONE_IDX, 0, 0, 0);
    step("rst",       1'b1, C_NONE,  0, 0, NONE_IDX, 0, 0, 0);
    step("idle",      1'b0, C_NONE,  0, 0, NONE_IDX, 0, 0, 0);

    // Three Start pulses: 1 high, 5 low each.
    for (int p = 0; p < 3; p++) begin
      step("start",  1'b0, C_START, 0, entry[p], p, 0, 0, 0);
      step("to_run", 1'b0, C_NONE,  0, entry[p], p, 1, 0, 0);
      for (int k = 1; k <= 4; k++) begin
        step("inc", 1'b0, C_NONE, 0, entry[p] + k, p, 1, 0, 0);
      end
    end
    step("start_wrap", 1'b0, C_START, 0, 0, NONE_IDX, 0, 0, 0);
    step("idle_wrap",  1'b0, C_NONE,  0, 0, NONE_IDX, 0, 0, 0);

    // Start held for 4 cycles.
    step("hold1", 1'b0, C_START, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step("hold", 1'b0, C_START, 0, 1, 0, 0, 0, 0);
    end
    step("release", 1'b0, C_NONE, 0, 1, 0, 1, 0, 0);
    step("inc2",    1'b0, C_NONE, 0, 2, 0, 1, 0, 0);
    step("inc3",    1'b0, C_NONE, 0, 3, 0, 1, 0, 0);

    // Relative and absolute branches, including modulo wrap.
    step("abs10", 1'b0, C_ABS, 10,  10,   0, 1, 0, 0);
    step("up3",   1'b0, C_UP,  3,   7,    0, 1, 0, 0);
    step("dn255", 1'b0, C_DN,  255, 262,  0, 1, 0, 0);
    step("dn255", 1'b0, C_DN,  255, 517,  0, 1, 0, 0);
    step("dn255", 1'b0, C_DN,  255, 772,  0, 1, 0, 0);
    step("dn228", 1'b0, C_DN,  228, 1000, 0, 1, 0, 0);
    step("dn_wrap", 1'b0, C_DN, 255, 231, 0, 1, 0, 0);
    step("abs40h", 1'b0, C_ABS, 8'h40, 64, 0, 1, 0, 0);

    // Priority.
    step("stall_pri", 1'b0, C_STALL | C_CALL | C_DN, 5, 64, 0, 1, 0, 0);
    step("call_pri",  1'b0, C_CALL | C_ABS, 5, 69, 0, 1, 0, 0);
    step("ret1",      1'b0, C_RET, 0, STK ? 65 : 70, 0, 1, 0, 0);

    // Nested calls from PC 20, offset 2; 5th overflows when the stack exists.
    step("abs20", 1'b0, C_ABS, 20, 20, 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) e = STK;
      step("call", 1'b0, C_CALL, 2, 20 + 2 * k, 0, 1, 0, e);
    end
    for (int k = 0; k < 5; k++) begin
      step("ret", 1'b0, C_RET, 0, STK ? ret_stk[k] : 31 + k, 0, 1, 0, e);
    end
    step("err_sticky", 1'b0, C_NONE, 0, STK ? 23 : 36, 0, 1, 0, e);

    // Program end via BranchAbs 0, then controls ignored in IDLE.
    step("end",      1'b0, C_ABS,  0, 0, 0, 0, 1, e);
    step("done_off", 1'b0, C_NONE, 0, 0, 0, 0, 0, e);
    step("idle_ign", 1'b0, C_DN,   5, 0, 0, 0, 0, e);

    // Reset in the middle of a call chain.
    step("start_p1", 1'b0, C_START, 0, 2, 1, 0, 0, e);
    step("run_p1",   1'b0, C_NONE,  0, 2, 1, 1, 0, e);
    step("call_a",   1'b0, C_CALL,  3, 5, 1, 1, 0, e);
    step("call_b",   1'b0, C_CALL,  3, 8, 1, 1, 0, e);
    e = 0;
    step("rst_mid",  1'b1, C_CALL,  3, 0, NONE_IDX, 0, 0, 0);
    step("post_rst", 1'b0, C_NONE,  0, 0, NONE_IDX, 0, 0, 0);
    step("start_p0", 1'b0, C_START, 0, 1, 0, 0, 0, 0);
    step("run_p0",   1'b0, C_NONE,  0, 1, 0, 1, 0, 0);
    // Stack was discarded by reset: Ret underflows when the stack exists.
    e = STK;
    step("ret_empty", 1'b0, C_RET,  0, 2, 0, 1, 0, e);
    step("last_inc",  1'b0, C_NONE, 0, 3, 0, 1, 0, e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
